// File: rtl/sys_defs.sv
// Shared rename-stage definitions: machine sizes, index types and the
// packet structs exchanged between the free list and its neighbours.
package sys_defs;

    localparam int NUM_PR   = 64;
    localparam int NUM_ARCH = 32;
    localparam int NUM_FL   = NUM_PR - NUM_ARCH;
    localparam int NUM_ROB  = 8;
    localparam int ZERO_REG = 31;

    localparam int PR_W     = $clog2(NUM_PR);
    localparam int ARCH_W   = $clog2(NUM_ARCH);
    localparam int ROB_W    = $clog2(NUM_ROB);
    localparam int FL_W     = $clog2(NUM_FL);
    localparam int FL_PTR_W = FL_W + 1;

    typedef logic [PR_W-1:0]     PR_idx_t;
    typedef logic [ARCH_W-1:0]   arch_idx_t;
    typedef logic [ROB_W-1:0]    rob_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

    // The zero register keeps its reset mapping (arch r -> PR r) forever.
    localparam PR_idx_t   ZERO_PR   = PR_idx_t'(ZERO_REG);
    localparam arch_idx_t ZERO_ARCH = arch_idx_t'(ZERO_REG);

    typedef struct packed {
        logic      dispatch_en;
        arch_idx_t dest_idx;
        rob_idx_t  rob_tail_idx;
        logic      retire_en;
        PR_idx_t   t_old_idx_head;
        logic      rollback_en;
        rob_idx_t  rob_rollback_idx;
    } FREELIST_PACKET_IN;

    typedef struct packed {
        PR_idx_t T_idx;
        logic    free_valid;
    } FREELIST_PACKET_OUT;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers for the rename stage, with one
// head-pointer checkpoint per ROB entry for branch-mispredict recovery.
module free_list
    import sys_defs::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dispatch_en,
    input  logic [ARCH_W-1:0]     dest_idx,
    input  logic [ROB_W-1:0]      ROB_tail_idx,
    input  logic                  retire_en,
    input  logic [PR_W-1:0]       T_old_idx_head,
    input  logic                  rollback_en,
    input  logic [ROB_W-1:0]      ROB_rollback_idx,
    output logic [PR_W-1:0]       T_idx,
    output logic                  free_valid,
    output logic [FL_PTR_W-1:0]   free_count
);

    FREELIST_PACKET_IN  pkt_in;
    FREELIST_PACKET_OUT pkt_out;

    PR_idx_t fl_q [NUM_FL];
    fl_ptr_t chk_q [NUM_ROB];
    fl_ptr_t head_q, head_d, tail_q, tail_d, free_count_q;
    fl_ptr_t count, head_post_pop;
    logic    is_zero, full, accept, pop, push;

    assign pkt_in = '{
        dispatch_en:      dispatch_en,
        dest_idx:         dest_idx,
        rob_tail_idx:     ROB_tail_idx,
        retire_en:        retire_en,
        t_old_idx_head:   T_old_idx_head,
        rollback_en:      rollback_en,
        rob_rollback_idx: ROB_rollback_idx
    };

    always_comb begin
        count   = tail_q - head_q;
        is_zero = (pkt_in.dest_idx == ZERO_ARCH);
        full    = (head_q[FL_W-1:0] == tail_q[FL_W-1:0]) && (head_q[FL_W] != tail_q[FL_W]);

        pkt_out.free_valid = (count != '0) || is_zero;
        pkt_out.T_idx      = is_zero ? ZERO_PR : fl_q[head_q[FL_W-1:0]];

        // A rollback squashes this cycle's dispatch; no bypass from a same-cycle retire.
        accept = en && pkt_in.dispatch_en && pkt_out.free_valid && !pkt_in.rollback_en;
        pop    = accept && !is_zero;
        push   = en && pkt_in.retire_en && (pkt_in.t_old_idx_head != ZERO_PR);

        head_post_pop = head_q + FL_PTR_W'(pop);
        head_d        = pkt_in.rollback_en ? chk_q[pkt_in.rob_rollback_idx] : head_post_pop;
        tail_d        = tail_q + FL_PTR_W'(push);
    end

    assign T_idx      = pkt_out.T_idx;
    assign free_valid = pkt_out.free_valid;
    assign free_count = free_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FL; i++) begin
                fl_q[i] <= PR_idx_t'(NUM_ARCH + i);
            end
            head_q       <= '0;
            tail_q       <= fl_ptr_t'(NUM_FL);
            free_count_q <= fl_ptr_t'(NUM_FL);
        end else if (en) begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= tail_d - head_d;
            if (push) begin
                fl_q[tail_q[FL_W-1:0]] <= pkt_in.t_old_idx_head;
            end
        end
    end

    // Checkpoints capture the head as it stands after this dispatch's own pop.
    generate
        for (genvar gi = 0; gi < NUM_ROB; gi++) begin : g_chk
            always_ff @(posedge clock) begin
                if (reset) begin
                    chk_q[gi] <= '0;
                end else if (accept && (pkt_in.rob_tail_idx == rob_idx_t'(gi))) begin
                    chk_q[gi] <= head_post_pop;
                end
            end
        end
    endgenerate

    push_while_full_a: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_free_list.sv
// Randomized bench for free_list: a queue-based model of the free pool,
// compared against the DUT every cycle, plus directed literal checks.
module tb_free_list;

    logic       clock = 1'b0;
    logic       reset, en, dispatch_en, retire_en, rollback_en;
    logic [4:0] dest_idx;
    logic [2:0] ROB_tail_idx, ROB_rollback_idx;
    logic [5:0] T_old_idx_head, T_idx, free_count;
    logic       free_valid;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_on = 1'b0;

    // Model: free_q is the allocatable pool in order, held are PRs in use,
    // popped is the allocation history so a rollback can return its tail.
    int  free_q[$];
    int  held[$];
    int  popped[$];
    int  pop_total;
    int  chk_pops[8];
    bit  chk_valid[8];

    free_list dut (
        .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
        .dest_idx(dest_idx), .ROB_tail_idx(ROB_tail_idx), .retire_en(retire_en),
        .T_old_idx_head(T_old_idx_head), .rollback_en(rollback_en),
        .ROB_rollback_idx(ROB_rollback_idx), .T_idx(T_idx),
        .free_valid(free_valid), .free_count(free_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_held(input int pr);
        for (int i = 0; i < held.size(); i++) if (held[i] == pr) return i;
        return -1;
    endfunction

    function automatic void del_held(input int pr);
        int k = find_held(pr);
        if (k >= 0) held.delete(k);
    endfunction

    function automatic bit in_last(input int pr, input int n);
        for (int k = 1; k <= n; k++) if (popped[popped.size()-k] == pr) return 1'b1;
        return 1'b0;
    endfunction

    // A rollback is only legal if everything it returns is still in use
    // and the pool would not exceed its capacity.
    function automatic bit rb_ok(input int idx, output int n);
        n = pop_total - chk_pops[idx];
        if (!chk_valid[idx] || n < 0 || n > popped.size()) return 1'b0;
        if (free_q.size() + n > 32) return 1'b0;
        for (int k = 1; k <= n; k++) if (find_held(popped[popped.size()-k]) < 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update();
        if (reset) begin
            free_q = {}; held = {}; popped = {};
            for (int i = 32; i < 64; i++) free_q.push_back(i);
            for (int i = 0; i < 31; i++) held.push_back(i);
            pop_total = 0;
            for (int i = 0; i < 8; i++) begin chk_pops[i] = 0; chk_valid[i] = 1'b1; end
        end else if (en) begin
            bit acc = dispatch_en && !rollback_en && (free_q.size() > 0 || dest_idx == 5'd31);
            if (rollback_en) begin
                int n = pop_total - chk_pops[ROB_rollback_idx];
                for (int k = 0; k < n; k++) begin
                    int r = popped.pop_back();
                    free_q.push_front(r);
                    del_held(r);
                end
                pop_total -= n;
                for (int i = 0; i < 8; i++) if (chk_pops[i] > pop_total) chk_valid[i] = 1'b0;
            end
            if (acc) begin
                if (dest_idx != 5'd31) begin
                    int t = free_q.pop_front();
                    popped.push_back(t);
                    held.push_back(t);
                    pop_total++;
                end
                chk_pops[ROB_tail_idx]  = pop_total;
                chk_valid[ROB_tail_idx] = 1'b1;
            end
            if (retire_en && T_old_idx_head != 6'd31) begin
                free_q.push_back(int'(T_old_idx_head));
                del_held(int'(T_old_idx_head));
            end
        end
    endtask

    task automatic drive(input bit e, input bit d, input int dst, input int rt,
                         input bit r, input int to, input bit rb, input int rbi);
        en = e; dispatch_en = d; dest_idx = 5'(dst); ROB_tail_idx = 3'(rt);
        retire_en = r; T_old_idx_head = 6'(to);
        rollback_en = rb; ROB_rollback_idx = 3'(rbi);
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            check("free_count", int'(free_count), free_q.size());
            check("free_valid", int'(free_valid), int'(free_q.size() > 0 || dest_idx == 5'd31));
            if (dest_idx == 5'd31) check("T_idx_zero", int'(T_idx), 31);
            else if (free_q.size() > 0) check("T_idx", int'(T_idx), free_q[0]);
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        chk_on = 1'b1;
        #1;
        check("rst_count", int'(free_count), 32);
        check("rst_valid", int'(free_valid), 1);
        check("rst_T", int'(T_idx), 32);

        // Three allocations from a fresh list.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i + 1, i, 0, 0, 0, 0); #1;
            check("alloc_T", int'(T_idx), 32 + i);
            tick();
        end
        drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
        check("alloc_count", int'(free_count), 29);

        // Zero register dispatch: no pop.
        drive(1, 1, 31, 0, 0, 0, 0, 0); #1;
        check("zero_T", int'(T_idx), 31);
        tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
        check("zero_count", int'(free_count), 29);
        check("zero_next_T", int'(T_idx), 35);

        // Branch at ROB 2 leaves head at 5, three more pops, then roll back.
        drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 4, 2, 0, 0, 0, 0); #1;
        check("br_T", int'(T_idx), 36);
        tick();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 5, 3 + i, 0, 0, 0, 0); tick(); end
        drive(1, 1, 7, 6, 0, 0, 1, 2); tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
        check("rb_count", int'(free_count), 27);
        check("rb_T", int'(T_idx), 37);

        // Pop 37..40, checkpoint at ROB 3 after popping 41, pop 42,
        // then roll back while retiring 40 in the same cycle.
        for (int i = 0; i < 4; i++) begin drive(1, 1, 6, 4 + i, 0, 0, 0, 0); tick(); end
        drive(1, 1, 6, 3, 0, 0, 0, 0); tick();
        drive(1, 1, 6, 4, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 1, 40, 1, 3); tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0); #1;
        check("rbret_count", int'(free_count), 23);
        check("rbret_T", int'(T_idx), 42);

        // Drain to empty; further requests must stall.
        drive(1, 1, 1, 0, 0, 0, 0, 0); #1;
        n = 0;
        while (free_valid && n < 40) begin tick(); n++; end
        check("drain_pops", n, 23);
        check("empty_valid", int'(free_valid), 0);
        check("empty_count", int'(free_count), 0);
        tick();
        check("blocked_count", int'(free_count), 0);
        drive(1, 1, 2, 0, 1, 5, 0, 0); #1;
        check("nobypass_valid", int'(free_valid), 0);
        tick();
        drive(1, 1, 2, 0, 0, 0, 0, 0); #1;
        check("freed_T", int'(T_idx), 5);
        check("freed_valid", int'(free_valid), 1);
        check("freed_count", int'(free_count), 1);
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        tick();

        // Randomized mix with stalls, wrap-around and legal rollbacks.
        for (int c = 0; c < 600; c++) begin
            bit e, d, r, rb;
            int dst, rt, to, rbi, nr;
            e   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            dst = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 30));
            rt  = int'($urandom_range(0, 7));
            rbi = int'($urandom_range(0, 7));
            r = 1'b0; to = 0; rb = 1'b0; nr = 0;
            if ($urandom_range(0, 7) == 0) rb = rb_ok(rbi, nr);
            if ($urandom_range(0, 1) == 1 && held.size() > 0 && free_q.size() < 32) begin
                r  = 1'b1;
                to = ($urandom_range(0, 9) == 0) ? 31 : held[$urandom_range(0, held.size() - 1)];
                if (rb && (free_q.size() + nr + 1 > 32 || in_last(to, nr))) r = 1'b0;
            end
            drive(e, d, dst, rt, r, to, rb, rbi);
            tick();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register indices for the R10000-style rename stage.
- Sits beside the ROB:
  - Dispatch pops a fresh physical register T for the map table and ROB.
  - ROB retire pushes the retiring entry's T_old back.
  - Branch rollback restores the pop pointer from a per-ROB-entry checkpoint, which reclaims every register allocated after the branch.

Parameters:
- NUM_PR, 64, number of physical registers.
- NUM_ARCH, 32, number of architectural registers; PR 0..NUM_ARCH-1 hold the initial mapping.
- NUM_FL, NUM_PR-NUM_ARCH (32), free-list capacity.
- NUM_ROB, 8, ROB entries, one checkpoint per entry.
- ZERO_REG, 31, architectural zero register; it never allocates.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  global stall; when 0, no state changes
- dispatch_en  in  1  dispatch request this cycle
- dest_idx  in  $clog2(NUM_ARCH)  dispatching instruction's architectural destination
- ROB_tail_idx  in  $clog2(NUM_ROB)  ROB slot being written this cycle
- retire_en  in  1  ROB head retiring this cycle
- T_old_idx_head  in  $clog2(NUM_PR)  T_old of the retiring ROB head
- rollback_en  in  1  mispredict recovery
- ROB_rollback_idx  in  $clog2(NUM_ROB)  ROB index of the mispredicted branch
- T_idx  out  $clog2(NUM_PR)  allocated physical register (combinational)
- free_valid  out  1  a register is available for this cycle's dispatch
- free_count  out  $clog2(NUM_FL)+1  registered occupancy

Behaviour:
- Storage: fl[NUM_FL] of PR indices.
  - head and tail are $clog2(NUM_FL)+1 bits; the MSB is a wrap bit.
  - count = tail - head (modular). Empty when head==tail. Full when the low bits are equal and the MSBs differ.
- Reset (synchronous, clock edge with reset=1):
  - fl[i] = NUM_ARCH+i; head = 0; tail = {1'b1, 0}, i.e. full with count 32.
  - All chk[] cleared to 0; free_count = 32; free_valid = 1.
  - Reset overrides all other inputs.
- Allocation is combinational:
  - T_idx = fl[head[low]] when dest_idx != ZERO_REG.
  - T_idx = ZERO_REG's fixed PR (index 31) when dest_idx == ZERO_REG.
  - free_valid = (count != 0) || (dest_idx == ZERO_REG).
- Pop: dispatch_en && en && free_valid && !rollback_en && dest_idx != ZERO_REG -> head+1 at the clock edge.
- Checkpoint: on every accepted dispatch (including ZERO_REG), chk[ROB_tail_idx] <= post-pop head value.
- Push: retire_en && en && T_old_idx_head != ZERO_REG's PR -> fl[tail[low]] <= T_old_idx_head and tail+1.
  - Push while full is illegal; a simulation-only assertion fires.
- Rollback: rollback_en && en -> head <= chk[ROB_rollback_idx]; dispatch is ignored that cycle.
  - A retire push in the same cycle still occurs.
  - Correctness rule: registers freed since the checkpoint sit behind tail and are not disturbed; popped-after-branch registers are still physically in fl[] because pops do not erase storage.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Pop at count==0: blocked; the ROB must not write its tail (free_valid feeds dispatch stall).
  - Pop and push at count==0 in the same cycle: the pop is still blocked (no bypass). Retired T_old is usable the next cycle.
- Wrap-around: pointers wrap modulo 2*NUM_FL; array index uses the low bits only.
- en==0: hold all state; outputs still reflect current state.
- Latency: allocation is available in the same cycle; a freed register is allocatable 1 cycle after retire.
- free_count is registered and equals count after each edge.

Decomposition:
- Shared package sys_defs: NUM_PR, NUM_ARCH, NUM_ROB, ZERO_REG, PR_idx_t.
- Shared packet structs:
  - FREELIST_PACKET_IN (dispatch/retire/rollback fields).
  - FREELIST_PACKET_OUT (T_idx, free_valid).
- Single module with no submodule. The checkpoint array is inline: NUM_ROB x ($clog2(NUM_FL)+1) flops.

Test Plan:
1. Reset, then 3 dispatches with dest 1,2,3 -> T_idx 32,33,34; free_count 29; head=3.
2. Dispatch dest=31 -> T_idx=31, head unchanged, chk written, free_count unchanged.
3. 32 dispatches without retire -> free_valid=0 with count 0. A 33rd request is not popped. A subsequent retire of T_old=5 yields T_idx=5 next cycle.
4. Dispatch branch at ROB idx 2 (head=5), then 3 more pops (head=8), then rollback ROB_rollback_idx=2 -> head=5, free_count +3, next T_idx equals the value allocated right after the branch.
5. Rollback in the same cycle as retire of T_old=40 -> head restored and tail+1; 40 is stored at the old tail slot; count = tail - restored head.
6. Run 100 mixed push/pop cycles past pointer wrap with en toggling -> count always equals the scoreboard; no duplicate PR in flight; en=0 cycles change nothing.
